sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Two-port round-robin arbiter in front of the `sdram_controller` host interface, in the 100 MHz SDRAM clock domain. Each requester issues single-word read or write requests. The arbiter serialises them onto the controller's `wr_*`/`rd_*`/`busy` handshake and routes each read result back to the port that issued it. This lets a second master share the DRAM with the existing FIFO-bridged host path.

## Interface
- `HADDR_WIDTH`, 24: host word address width.
- `DATA_WIDTH`, 16: data word width.

- `clk` in 1: controller clock, 100 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `req0` / `req1` in 1: request valid; held until acked.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in HADDR_WIDTH: request address.
- `wdata0` / `wdata1` in DATA_WIDTH: write data.
- `ack0` / `ack1` out 1: one-cycle pulse; request accepted and issued.
- `rvalid0` / `rvalid1` out 1: one-cycle pulse; `rdata` belongs to this port.
- `rdata` out DATA_WIDTH: registered read data, shared by both ports.
- `wr_addr` out HADDR_WIDTH: to controller.
- `wr_data` out DATA_WIDTH: to controller.
- `wr_enable` out 1: to controller.
- `rd_addr` out HADDR_WIDTH: to controller.
- `rd_enable` out 1: to controller.
- `busy` in 1: from controller.
- `rd_data` in DATA_WIDTH: from controller.
- `rd_ready` in 1: from controller.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - Stays in IDLE while `busy`=1, e.g. during a refresh.
  - Otherwise, if any `reqN`=1, selects a winner and goes to ISSUE.
- **Round-robin selection:**
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- **ISSUE (one cycle):**
  - Latches `owner` and `op`.
  - Drives the winner's address and data onto `wr_addr`/`wr_data` or `rd_addr` according to `we`.
  - Asserts exactly one of `wr_enable`/`rd_enable` for this single cycle.
  - Pulses `ackN` for the winner and updates `last_grant`.
  - Next state is WAIT_BUSY.
- **WAIT_BUSY:** holds until `busy`=1, then goes to WAIT_DONE.
- **WAIT_DONE:**
  - Holds until `busy`=0.
  - On a read, when `rd_ready`=1: registers `rd_data` into `rdata` and pulses `rvalid[owner]` on the next cycle.
  - Returns to IDLE when `busy`=0, provided a pending read has completed. A read must not release before `rd_ready` has been seen.
- **Address/data outputs:** `wr_addr`, `wr_data` and `rd_addr` are registered and hold their value outside ISSUE.
- **Stray `rd_ready`:** if `rd_ready` arrives while the latched op is a write, or outside WAIT_BUSY/WAIT_DONE, it is ignored and no `rvalid` is pulsed.
- **Dropped requests:** a `req` that falls before its ack is dropped with no side effects; the bench flags it as a protocol violation.
- **Reset mid-operation:**
  - FSM returns to IDLE asynchronously.
  - Enables, acks and rvalids clear immediately.
  - An in-flight controller read result is discarded.

## Timing
- **Reset values:** all outputs 0; `last_grant`=1; state IDLE.
- **Request to enable:**
  - A request seen in IDLE at edge k, with `busy`=0, gives `ack` and enable high during cycle k+1.
  - The controller samples the enable at edge k+2.
- **Read data:** `rvalid`/`rdata` are valid one cycle after `rd_ready`.
- **Throughput:** at most one outstanding controller operation. There are at least 2 idle cycles between consecutive enables (ISSUE → WAIT_BUSY → … → IDLE → ISSUE).
- **Exclusivity:** `wr_enable` and `rd_enable` are never high together, and `ack0` and `ack1` are never high together.

## Structure
- **Package `sdram_arb_pkg`:**
  - State enum `arb_state_t` {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE}.
  - `ARB_PORTS` = 2.
  - Op encoding: `OP_RD`=0, `OP_WR`=1.
- **Sub-module `rr_arbiter2`:** combinational winner from `req[1:0]` and `last_grant`. It is instantiated once; the FSM and datapath registers live in the top.

## Test plan
- **Single write:**
  - Stimulus: reset; `req0`, `we0`=1, `addr0`=0x000123, `wdata0`=0xBEEF; controller model asserts `busy` for 5 cycles.
  - Required: `wr_enable` high for exactly 1 cycle with `wr_addr`=0x000123 and `wr_data`=0xBEEF; `ack0` pulses once; FSM back in IDLE after `busy` falls.
- **Routed read:**
  - Stimulus: `req1` read at `addr1`=0x00ABCD; model returns 0x1234 with `rd_ready`.
  - Required: `rd_addr`=0x00ABCD; `rvalid1`=1 with `rdata`=0x1234 one cycle after `rd_ready`; `rvalid0` stays 0.
- **Simultaneous requests:**
  - Stimulus: both ports hold `req` for 4 transactions.
  - Required: ack order 0, 1, 0, 1; never two enables in flight.
- **Busy gating:**
  - Stimulus: `busy`=1 (refresh) while `req0` is raised.
  - Required: no enable until `busy` falls; enable two edges after it falls.
- **Reset mid-read:**
  - Stimulus: assert `rst` during WAIT_DONE, with `rd_ready` arriving afterwards.
  - Required: all outputs 0 immediately; no `rvalid` pulse; the next request is served normally.
- **Stray `rd_ready` during a write:** required: no `rvalid` on either port.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
//   arb_state_t : arbiter FSM states
//   ARB_PORTS   : number of requester ports
//   OP_RD/OP_WR : encoding of the latched operation
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int unsigned ARB_PORTS = 2;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin winner selection.
//   req        : request vector, bit N = port N
//   last_grant : index of the port granted most recently
//   gnt_valid  : at least one port is requesting
//   gnt_idx    : index of the winning port (valid when gnt_valid)
module rr_arbiter2
   import sdram_arb_pkg::*;
(
   input  logic [ARB_PORTS-1:0] req,
   input  logic                 last_grant,
   output logic                 gnt_valid,
   output logic                 gnt_idx
);

   always_comb begin
      gnt_valid = |req;
      case (req)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         // Tie goes to the port that was not served last.
         2'b11:   gnt_idx = ~last_grant;
         default: gnt_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of the sdram_controller host interface.
// Serialises single-word requests onto the wr_*/rd_*/busy handshake and routes
// each read result back to the issuing port.
//   clk, rst                  : controller clock, async active-high reset
//   reqN/weN/addrN/wdataN     : port N request (held until ackN)
//   ackN                      : one-cycle pulse, request issued to the controller
//   rvalidN, rdata            : one-cycle read-return pulse, shared read data
//   wr_addr/wr_data/wr_enable : controller write command
//   rd_addr/rd_enable         : controller read command
//   busy/rd_data/rd_ready     : controller status and read return
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int HADDR_WIDTH = 24,
   parameter int DATA_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0,
   input  logic                   req1,
   input  logic                   we0,
   input  logic                   we1,
   input  logic [HADDR_WIDTH-1:0] addr0,
   input  logic [HADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0]  wdata0,
   input  logic [DATA_WIDTH-1:0]  wdata1,
   output logic                   ack0,
   output logic                   ack1,
   output logic                   rvalid0,
   output logic                   rvalid1,
   output logic [DATA_WIDTH-1:0]  rdata,
   output logic [HADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0]  wr_data,
   output logic                   wr_enable,
   output logic [HADDR_WIDTH-1:0] rd_addr,
   output logic                   rd_enable,
   input  logic                   busy,
   input  logic [DATA_WIDTH-1:0]  rd_data,
   input  logic                   rd_ready
);

   arb_state_t                 state_q, state_d;
   logic                       last_grant_q, last_grant_d;
   logic                       owner_q, owner_d;
   logic                       op_q, op_d;
   logic                       rd_done_q, rd_done_d;
   logic [HADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
   logic [HADDR_WIDTH-1:0]     rd_addr_q, rd_addr_d;
   logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic                       wr_enable_q, wr_enable_d;
   logic                       rd_enable_q, rd_enable_d;
   logic [ARB_PORTS-1:0]       ack_q, ack_d;
   logic [ARB_PORTS-1:0]       rvalid_q, rvalid_d;

   logic                       gnt_valid;
   logic                       gnt_idx;
   logic                       win_we;
   logic [HADDR_WIDTH-1:0]     win_addr;
   logic [DATA_WIDTH-1:0]      win_wdata;
   logic                       rd_take;

   rr_arbiter2 u_rr (
      .req        ({req1, req0}),
      .last_grant (last_grant_q),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   assign win_we    = gnt_idx ? we1    : we0;
   assign win_addr  = gnt_idx ? addr1  : addr0;
   assign win_wdata = gnt_idx ? wdata1 : wdata0;

   // Only the first rd_ready of an outstanding read counts; stray ones are dropped.
   assign rd_take = ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) &&
                    (op_q == OP_RD) && !rd_done_q && rd_ready;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      op_d         = op_q;
      rd_done_d    = rd_done_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      rd_addr_d    = rd_addr_q;
      rdata_d      = rdata_q;
      wr_enable_d  = 1'b0;
      rd_enable_d  = 1'b0;
      ack_d        = '0;
      rvalid_d     = '0;

      case (state_q)
         IDLE: begin
            // Command registers load on entry so ack and enable are high
            // throughout the single ISSUE cycle.
            if (!busy && gnt_valid) begin
               state_d          = ISSUE;
               owner_d          = gnt_idx;
               op_d             = win_we ? OP_WR : OP_RD;
               last_grant_d     = gnt_idx;
               rd_done_d        = 1'b0;
               ack_d[gnt_idx]   = 1'b1;
               if (win_we) begin
                  wr_addr_d   = win_addr;
                  wr_data_d   = win_wdata;
                  wr_enable_d = 1'b1;
               end else begin
                  rd_addr_d   = win_addr;
                  rd_enable_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // A read may not release before its data has been returned.
            if (!busy && ((op_q == OP_WR) || rd_done_q || rd_take)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rd_take) begin
         rdata_d           = rd_data;
         rvalid_d[owner_q] = 1'b1;
         rd_done_d         = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         op_q         <= OP_RD;
         rd_done_q    <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         rd_addr_q    <= '0;
         rdata_q      <= '0;
         wr_enable_q  <= 1'b0;
         rd_enable_q  <= 1'b0;
         ack_q        <= '0;
         rvalid_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         op_q         <= op_d;
         rd_done_q    <= rd_done_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         rd_addr_q    <= rd_addr_d;
         rdata_q      <= rdata_d;
         wr_enable_q  <= wr_enable_d;
         rd_enable_q  <= rd_enable_d;
         ack_q        <= ack_d;
         rvalid_q     <= rvalid_d;
      end
   end

   assign ack0      = ack_q[0];
   assign ack1      = ack_q[1];
   assign rvalid0   = rvalid_q[0];
   assign rvalid1   = rvalid_q[1];
   assign rdata     = rdata_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign wr_enable = wr_enable_q;
   assign rd_addr   = rd_addr_q;
   assign rd_enable = rd_enable_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a behavioural controller model plus a
// reference model that predicts grant order from the round-robin rule and read
// data from a plain memory array.
module tb_sdram_arbiter;

   localparam int AW = 24;
   localparam int DW = 16;

   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data;
   logic          wr_enable, rd_enable;
   logic          busy, rd_ready;
   logic [DW-1:0] rd_data;

   logic          ctl_busy = 1'b0;
   logic          refresh;
   assign busy = ctl_busy | refresh;

   int total = 0;
   int bad   = 0;

   txn_t          exp_q[$];
   txn_t          mt;
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW-1:0] dram    [logic [AW-1:0]];
   int            ref_last;

   // Controller model state
   int            ctl_phase = 0;
   int            ctl_cnt, ctl_len, ctl_rdy_at;
   logic          ctl_we;
   logic [AW-1:0] ctl_addr;
   int            ctl_len_force = 0;
   logic          ctl_rdy_late  = 1'b0;
   int            stray_asked = 0;
   int            stray_done  = 0;

   // Expected read-return bookkeeping
   logic          rd_pend = 1'b0;
   int            rd_pend_port;
   logic [DW-1:0] rd_pend_data;
   logic [1:0]    rv_exp = 2'b00;
   logic [DW-1:0] rv_exp_data;
   logic [AW-1:0] hold_wa, hold_ra;
   logic [DW-1:0] hold_wd;

   // Stimulus scratch
   logic [1:0]    sel;
   logic          rw0, rw1;
   logic [AW-1:0] ra0, ra1;
   logic [DW-1:0] rd0, rd1;
   int            n;

   always #5 clk = ~clk;

   sdram_arbiter #(
      .HADDR_WIDTH (AW),
      .DATA_WIDTH  (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack0      (ack0),
      .ack1      (ack1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata     (rdata),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_enable (wr_enable),
      .rd_addr   (rd_addr),
      .rd_enable (rd_enable),
      .busy      (busy),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return a[DW-1:0] ^ 16'h5A5A;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // Monitor and controller model, both evaluated on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         rv_exp  = 2'b00;
         rd_pend = 1'b0;
         hold_wa = '0;
         hold_wd = '0;
         hold_ra = '0;
      end else begin
         check_eq("excl", 64'({wr_enable & rd_enable, ack0 & ack1}), 64'd0);
         check_eq("rvalid", 64'({rvalid1, rvalid0}), 64'(rv_exp));
         if (rv_exp != 2'b00) check_eq("rdata", 64'(rdata), 64'(rv_exp_data));
         rv_exp = 2'b00;
         if (ack0 | ack1 | wr_enable | rd_enable) begin
            if (exp_q.size() == 0) begin
               check_eq("unexp_issue", 64'({ack1, ack0, wr_enable, rd_enable}), 64'd0);
            end else begin
               mt = exp_q.pop_front();
               check_eq("in_flight", 64'(ctl_phase), 64'd0);
               check_eq("ack_port", 64'({ack1, ack0}), (mt.port == 1) ? 64'd2 : 64'd1);
               check_eq("op", 64'({wr_enable, rd_enable}), mt.we ? 64'd2 : 64'd1);
               if (mt.we) begin
                  hold_wa = mt.addr;
                  hold_wd = mt.data;
               end else begin
                  hold_ra      = mt.addr;
                  rd_pend      = 1'b1;
                  rd_pend_port = mt.port;
                  rd_pend_data = mt.data;
               end
            end
         end
         check_eq("addr_data", 64'({wr_addr, wr_data, rd_addr}), 64'({hold_wa, hold_wd, hold_ra}));
      end

      rd_ready = 1'b0;
      case (ctl_phase)
         0: begin
            if (!rst && (wr_enable || rd_enable)) begin
               ctl_we   = wr_enable;
               ctl_addr = wr_enable ? wr_addr : rd_addr;
               if (wr_enable) dram[wr_addr] = wr_data;
               ctl_cnt    = $urandom_range(0, 2);
               ctl_len    = (ctl_len_force != 0) ? ctl_len_force : $urandom_range(1, 5);
               ctl_rdy_at = ctl_rdy_late ? ctl_len : $urandom_range(1, ctl_len);
               ctl_phase  = 1;
            end else if (stray_done != stray_asked) begin
               rd_ready   = 1'b1;
               rd_data    = 16'($urandom);
               stray_done = stray_asked;
            end
         end
         1: begin
            if (ctl_cnt == 0) begin
               ctl_phase = 2;
               ctl_cnt   = 0;
            end else begin
               ctl_cnt--;
            end
         end
         default: ;
      endcase
      if (ctl_phase == 2) begin
         ctl_cnt++;
         if (ctl_cnt > ctl_len) begin
            ctl_busy  = 1'b0;
            ctl_phase = 0;
         end else begin
            ctl_busy = 1'b1;
            if (ctl_cnt == ctl_rdy_at) begin
               if (!ctl_we) begin
                  rd_ready = 1'b1;
                  rd_data  = dram.exists(ctl_addr) ? dram[ctl_addr] : init_val(ctl_addr);
                  if (rd_pend && !rst) begin
                     rv_exp[rd_pend_port] = 1'b1;
                     rv_exp_data          = rd_pend_data;
                     rd_pend              = 1'b0;
                  end
               end else if ($urandom_range(0, 1) == 1) begin
                  // Stray rd_ready during a write
                  rd_ready = 1'b1;
                  rd_data  = 16'($urandom);
               end
            end
         end
      end
   end

   // Reference model: grant order from the round-robin rule, data from ref_mem.
   task automatic plan(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      int   order[2];
      int   n_ord;
      txn_t t;
      n_ord = 0;
      if (r0 && r1) begin
         order[0] = (ref_last == 1) ? 0 : 1;
         order[1] = 1 - order[0];
         n_ord    = 2;
      end else if (r0) begin
         order[0] = 0;
         n_ord    = 1;
      end else if (r1) begin
         order[0] = 1;
         n_ord    = 1;
      end
      for (int i = 0; i < n_ord; i++) begin
         t.port = order[i];
         t.we   = (t.port == 1) ? w1 : w0;
         t.addr = (t.port == 1) ? a1 : a0;
         if (t.we) begin
            t.data          = (t.port == 1) ? d1 : d0;
            ref_mem[t.addr] = t.data;
         end else begin
            t.data = ref_rd(t.addr);
         end
         exp_q.push_back(t);
         ref_last = order[i];
      end
   endtask

   task automatic wait_quiet();
      int k;
      k = 0;
      while ((ctl_phase != 0 || busy || exp_q.size() != 0) && k < 300) begin
         @(negedge clk); #1;
         k++;
      end
      if (k >= 300) check_eq("quiet_timeout", 64'd1, 64'd0);
      repeat (2) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic do_round(input logic r0, input logic r1, input logic w0, input logic w1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      logic p0, p1;
      int   lat;
      plan(r0, r1, w0, w1, a0, a1, d0, d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      p0   = r0;
      p1   = r1;
      lat  = 0;
      while ((p0 || p1) && lat < 300) begin
         @(negedge clk); #1;
         lat++;
         if (lat == 1) check_eq("ack_latency", 64'(ack0 | ack1), 64'd1);
         if (ack0) begin req0 = 1'b0; p0 = 1'b0; end
         if (ack1) begin req1 = 1'b0; p1 = 1'b0; end
      end
      if (p0 || p1) begin
         check_eq("ack_timeout", 64'({p1, p0}), 64'd0);
         req0 = 1'b0;
         req1 = 1'b0;
      end
      wait_quiet();
   endtask

   initial begin
      rst = 1'b1; refresh = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      ref_last = 1;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_ctl", 64'({ack0, ack1, rvalid0, rvalid1, wr_enable, rd_enable}), 64'd0);
      check_eq("rst_rdata", 64'(rdata), 64'd0);
      check_eq("rst_addr", 64'({wr_addr, wr_data, rd_addr}), 64'd0);
      rst = 1'b0;
      repeat (2) begin @(negedge clk); #1; end

      // Single write, controller busy for 5 cycles
      ctl_len_force = 5;
      do_round(1'b1, 1'b0, 1'b1, 1'b0, 24'h000123, '0, 16'hBEEF, '0);
      ctl_len_force = 0;

      // Routed read on port 1
      dram[24'h00ABCD]    = 16'h1234;
      ref_mem[24'h00ABCD] = 16'h1234;
      do_round(1'b0, 1'b1, 1'b0, 1'b0, '0, 24'h00ABCD, '0, '0);

      // Simultaneous requests: expected order 0,1,0,1
      do_round(1'b1, 1'b1, 1'b1, 1'b0, 24'h000010, 24'h000010, 16'h1111, '0);
      do_round(1'b1, 1'b1, 1'b0, 1'b1, 24'h000010, 24'h000020, '0, 16'h2222);

      // Busy gating: request during refresh
      refresh = 1'b1;
      @(negedge clk); #1;
      plan(1'b1, 1'b0, 1'b1, 1'b0, 24'h000777, '0, 16'hCAFE, '0);
      req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000777; wdata0 = 16'hCAFE;
      repeat (4) begin
         @(negedge clk); #1;
         check_eq("gated", 64'({ack0, wr_enable, rd_enable}), 64'd0);
      end
      refresh = 1'b0;
      @(negedge clk); #1;
      check_eq("ungated", 64'({ack0, wr_enable}), 64'd3);
      req0 = 1'b0;
      wait_quiet();

      // Stray rd_ready while idle
      stray_asked++;
      repeat (3) begin @(negedge clk); #1; end

      // Randomised traffic
      for (int i = 0; i < 60; i++) begin
         sel = 2'($urandom_range(1, 3));
         rw0 = 1'($urandom_range(0, 1));
         rw1 = 1'($urandom_range(0, 1));
         ra0 = 24'h3A0000 + 24'($urandom_range(0, 7));
         ra1 = 24'h3A0000 + 24'($urandom_range(0, 7));
         rd0 = 16'($urandom);
         rd1 = 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            stray_asked++;
            repeat (2) begin @(negedge clk); #1; end
         end
         do_round(sel[0], sel[1], rw0, rw1, ra0, ra1, rd0, rd1);
      end

      // Reset during WAIT_DONE of a read; rd_ready arrives afterwards
      ctl_len_force = 5;
      ctl_rdy_late  = 1'b1;
      plan(1'b0, 1'b1, 1'b0, 1'b0, '0, 24'h000042, '0, '0);
      req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000042;
      n = 0;
      while (!ack1 && n < 50) begin @(negedge clk); #1; n++; end
      check_eq("rst_test_ack", 64'(ack1), 64'd1);
      req1 = 1'b0;
      n = 0;
      while (ctl_phase != 2 && n < 50) begin @(negedge clk); #1; n++; end
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check_eq("midrst_ctl", 64'({ack0, ack1, rvalid0, rvalid1, wr_enable, rd_enable}), 64'd0);
      check_eq("midrst_rdata", 64'(rdata), 64'd0);
      check_eq("midrst_addr", 64'({wr_addr, wr_data, rd_addr}), 64'd0);
      ref_last = 1;
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      ctl_len_force = 0;
      ctl_rdy_late  = 1'b0;
      wait_quiet();

      // Normal service after reset; tie must go to port 0 again
      do_round(1'b1, 1'b1, 1'b0, 1'b1, 24'h3A0001, 24'h000055, '0, 16'h5555);
      do_round(1'b1, 1'b0, 1'b0, 1'b0, 24'h000055, '0, '0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
